// File: rtl/kv_cache_seq_if.sv
// Command, SRAM0 and KV-bank signal bundle of the KV cache sequencer.
// master = decoder/memory side, slave = sequencer.
interface kv_cache_seq_if #(
   parameter int N_LAYERS = 4,
   parameter int N_HEADS  = 4,
   parameter int MAX_T    = 64,
   parameter int HEAD_DIM = 64,
   parameter int DW       = 8,
   parameter int SRAM_AW  = 16
);
   localparam int KV_AW = 1 + $clog2(N_LAYERS) + $clog2(N_HEADS) + $clog2(MAX_T) + $clog2(HEAD_DIM);

   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_is_read;
   logic               cmd_is_v;
   logic [15:0]        cmd_layer;
   logic [15:0]        cmd_head;
   logic [15:0]        cmd_time;
   logic [15:0]        cmd_len;
   logic [SRAM_AW-1:0] cmd_sram_addr;

   logic               sram_rd_en;
   logic [SRAM_AW-1:0] sram_rd_addr;
   logic [DW-1:0]      sram_rd_data;
   logic               sram_wr_en;
   logic [SRAM_AW-1:0] sram_wr_addr;
   logic [DW-1:0]      sram_wr_data;

   logic               kv_rd_en;
   logic [KV_AW-1:0]   kv_rd_addr;
   logic [DW-1:0]      kv_rd_data;
   logic               kv_wr_en;
   logic [KV_AW-1:0]   kv_wr_addr;
   logic [DW-1:0]      kv_wr_data;

   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output cmd_valid, cmd_is_read, cmd_is_v, cmd_layer, cmd_head, cmd_time, cmd_len,
             cmd_sram_addr, sram_rd_data, kv_rd_data,
      input  cmd_ready, sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
             kv_rd_en, kv_rd_addr, kv_wr_en, kv_wr_addr, kv_wr_data, busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_is_read, cmd_is_v, cmd_layer, cmd_head, cmd_time, cmd_len,
             cmd_sram_addr, sram_rd_data, kv_rd_data,
      output cmd_ready, sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
             kv_rd_en, kv_rd_addr, kv_wr_en, kv_wr_addr, kv_wr_data, busy, done, err
   );
endinterface

// File: rtl/kv_cache_seq.sv
// KV cache APPEND/READ sequencer: done at L+2 (APPEND), T*L+2 (READ), 1 (reject/empty); no backpressure,
// cmd_ready only in IDLE, memories have fixed 1-cycle read latency. KV_PERF_CNT_EN adds perf counters.
module kv_cache_seq #(
   parameter int N_LAYERS = 4,
   parameter int N_HEADS  = 4,
   parameter int MAX_T    = 64,
   parameter int HEAD_DIM = 64,
   parameter int DW       = 8,
   parameter int SRAM_AW  = 16
) (
   input  logic          clk,
   input  logic          rst,
   kv_cache_seq_if.slave bus
`ifdef KV_PERF_CNT_EN
   ,
   input  logic          perf_clr,
   output logic [31:0]   perf_cycles,
   output logic [31:0]   perf_elems,
   output logic [15:0]   perf_errs
`endif
);
   localparam int LW    = $clog2(N_LAYERS);
   localparam int HW    = $clog2(N_HEADS);
   localparam int TW    = $clog2(MAX_T);
   localparam int DIW   = $clog2(HEAD_DIM);
   localparam int KV_AW = 1 + LW + HW + TW + DIW;
   localparam logic [DIW:0] D_ONE = (DIW+1)'(1);
   localparam logic [TW:0]  T_ONE = (TW+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t state_q, state_d;

   logic               is_read_q, is_v_q, err_q;
   logic [LW-1:0]      layer_q;
   logic [HW-1:0]      head_q;
   logic [TW:0]        time_q;
   logic [DIW:0]       len_q;
   logic [SRAM_AW-1:0] base_q, row_q;
   logic [DIW-1:0]     d_q;
   logic [TW-1:0]      t_q;
   logic               wr_vld_q;
   logic [SRAM_AW-1:0] wr_sram_addr_q;
   logic [KV_AW-1:0]   wr_kv_addr_q;

   logic               cmd_err, cmd_empty, d_last, t_last, issue_last;
   logic [KV_AW-1:0]   kv_addr_cur;

   assign cmd_err = (bus.cmd_layer >= 16'(N_LAYERS)) || (bus.cmd_head >= 16'(N_HEADS))
                 || (bus.cmd_len > 16'(HEAD_DIM))
                 || (!bus.cmd_is_read && (bus.cmd_time >= 16'(MAX_T)))
                 || ( bus.cmd_is_read && (bus.cmd_time >  16'(MAX_T)));
   assign cmd_empty   = (bus.cmd_len == 16'd0) || (bus.cmd_is_read && (bus.cmd_time == 16'd0));
   assign d_last      = ({1'b0, d_q} + D_ONE) == len_q;
   assign t_last      = ({1'b0, t_q} + T_ONE) == time_q;
   assign issue_last  = d_last && (!is_read_q || t_last);
   // For APPEND t_q holds the latched time index, so one concatenation serves both directions.
   assign kv_addr_cur = {is_v_q, layer_q, head_q, t_q, d_q};

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.cmd_valid) state_d = (cmd_err || cmd_empty) ? S_DONE : S_RUN;
         S_RUN:   if (issue_last) state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready    = (state_q == S_IDLE);
      bus.busy         = (state_q != S_IDLE);
      bus.done         = (state_q == S_DONE);
      bus.err          = (state_q == S_DONE) && err_q;
      bus.sram_rd_en   = (state_q == S_RUN) && !is_read_q;
      bus.sram_rd_addr = base_q + SRAM_AW'(d_q);
      bus.kv_rd_en     = (state_q == S_RUN) && is_read_q;
      bus.kv_rd_addr   = kv_addr_cur;
      bus.kv_wr_en     = wr_vld_q && !is_read_q;
      bus.kv_wr_addr   = wr_kv_addr_q;
      bus.kv_wr_data   = DW'(bus.sram_rd_data);
      bus.sram_wr_en   = wr_vld_q && is_read_q;
      bus.sram_wr_addr = wr_sram_addr_q;
      bus.sram_wr_data = DW'(bus.kv_rd_data);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         is_read_q      <= 1'b0;
         is_v_q         <= 1'b0;
         err_q          <= 1'b0;
         layer_q        <= '0;
         head_q         <= '0;
         time_q         <= '0;
         len_q          <= '0;
         base_q         <= '0;
         row_q          <= '0;
         d_q            <= '0;
         t_q            <= '0;
         wr_vld_q       <= 1'b0;
         wr_sram_addr_q <= '0;
         wr_kv_addr_q   <= '0;
      end else begin
         wr_vld_q <= (state_q == S_RUN);
         if (state_q == S_IDLE && bus.cmd_valid) begin
            is_read_q <= bus.cmd_is_read;
            is_v_q    <= bus.cmd_is_v;
            err_q     <= cmd_err;
            layer_q   <= bus.cmd_layer[LW-1:0];
            head_q    <= bus.cmd_head[HW-1:0];
            time_q    <= bus.cmd_time[TW:0];
            len_q     <= bus.cmd_len[DIW:0];
            base_q    <= bus.cmd_sram_addr;
            row_q     <= bus.cmd_sram_addr;
            d_q       <= '0;
            t_q       <= bus.cmd_is_read ? '0 : bus.cmd_time[TW-1:0];
         end else if (state_q == S_RUN) begin
            wr_kv_addr_q   <= kv_addr_cur;
            // row_q tracks base + t*len, so the READ destination needs no multiplier.
            wr_sram_addr_q <= row_q + SRAM_AW'(d_q);
            if (d_last) begin
               d_q <= '0;
               if (is_read_q) begin
                  t_q   <= t_q + TW'(1);
                  row_q <= row_q + SRAM_AW'(len_q);
               end
            end else begin
               d_q <= d_q + DIW'(1);
            end
         end
      end
   end

`ifdef KV_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || perf_clr) begin
         perf_cycles <= '0;
         perf_elems  <= '0;
         perf_errs   <= '0;
      end else begin
         if ((state_q != S_IDLE) && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
         if (wr_vld_q && (perf_elems != '1))             perf_elems  <= perf_elems + 32'd1;
         if ((state_q == S_DONE) && err_q && (perf_errs != '1)) perf_errs <= perf_errs + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_kv_cache_seq.sv
// Self-checking bench for kv_cache_seq: directed vector table, corner sequences, randomized commands.
module tb_kv_cache_seq;
   localparam int NL = 4, NH = 4, MT = 64, HD = 64, DW = 8, SAW = 16;
   localparam int KV_AW = 1 + $clog2(NL) + $clog2(NH) + $clog2(MT) + $clog2(HD);

   typedef struct {
      bit is_read; bit is_v;
      int layer; int head; int tim; int len; int addr;
      bit exp_err; int exp_done;
   } vec_t;

   typedef struct { bit is_sram; int addr; int data; int cyc; } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   int   bad_strobes = 0;
   bit   cur_is_read = 1'b0;
   wr_t  obs_q[$];
   wr_t  exp_q[$];

   logic [7:0] sram_mem [0:65535];
   logic [7:0] ref_sram [0:65535];
   logic [7:0] kv_mem   [0:(1<<KV_AW)-1];
   logic [7:0] ref_kv   [0:(1<<KV_AW)-1];

   kv_cache_seq_if #(.N_LAYERS(NL), .N_HEADS(NH), .MAX_T(MT), .HEAD_DIM(HD), .DW(DW), .SRAM_AW(SAW)) bus();

`ifdef KV_PERF_CNT_EN
   logic        perf_clr = 1'b0;
   logic [31:0] perf_cycles, perf_elems;
   logic [15:0] perf_errs;
`endif

   kv_cache_seq #(.N_LAYERS(NL), .N_HEADS(NH), .MAX_T(MT), .HEAD_DIM(HD), .DW(DW), .SRAM_AW(SAW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
`ifdef KV_PERF_CNT_EN
      , .perf_clr(perf_clr), .perf_cycles(perf_cycles), .perf_elems(perf_elems), .perf_errs(perf_errs)
`endif
   );

   always #5 clk = ~clk;

   // SRAM0 and bank environment: 1-cycle registered reads, writes at the clock edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.sram_rd_en) bus.sram_rd_data <= sram_mem[bus.sram_rd_addr];
      if (bus.kv_rd_en)   bus.kv_rd_data   <= kv_mem[bus.kv_rd_addr];
      if (bus.sram_wr_en) sram_mem[bus.sram_wr_addr] <= bus.sram_wr_data;
      if (bus.kv_wr_en)   kv_mem[bus.kv_wr_addr]     <= bus.kv_wr_data;
   end

   always @(negedge clk) begin
      if (bus.kv_wr_en)   obs_q.push_back('{1'b0, int'(bus.kv_wr_addr), int'(bus.kv_wr_data), cyc});
      if (bus.sram_wr_en) obs_q.push_back('{1'b1, int'(bus.sram_wr_addr), int'(bus.sram_wr_data), cyc});
      if ( cur_is_read && (bus.sram_rd_en || bus.kv_wr_en)) bad_strobes++;
      if (!cur_is_read && (bus.kv_rd_en || bus.sram_wr_en)) bad_strobes++;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      else passed++;
   endtask

   function automatic vec_t mk(bit r, bit v, int l, int h, int t, int n, int a, bit e, int dc);
      vec_t x;
      x.is_read = r; x.is_v = v; x.layer = l; x.head = h; x.tim = t; x.len = n; x.addr = a;
      x.exp_err = e; x.exp_done = dc;
      return x;
   endfunction

   function automatic int kvaddr(int v, int l, int h, int t, int d);
      return (((v * NL + l) * NH + h) * MT + t) * HD + d;
   endfunction

   // Reference: applies the command to shadow memories and lists the writes it must cause.
   task automatic model_cmd(input vec_t v, output bit e, output int dc);
      int ka, sa;
      logic [7:0] x;
      e = (v.layer >= NL) || (v.head >= NH) || (v.len > HD)
       || (!v.is_read && v.tim >= MT) || (v.is_read && v.tim > MT);
      dc = 1;
      if (e || v.len == 0 || (v.is_read && v.tim == 0)) return;
      if (!v.is_read) begin
         for (int d = 0; d < v.len; d++) begin
            ka = kvaddr(v.is_v, v.layer, v.head, v.tim, d);
            x  = ref_sram[(v.addr + d) % 65536];
            ref_kv[ka] = x;
            exp_q.push_back('{1'b0, ka, int'(x), 2 + d});
         end
         dc = v.len + 2;
      end else begin
         for (int t = 0; t < v.tim; t++)
            for (int d = 0; d < v.len; d++) begin
               sa = (v.addr + t * v.len + d) % 65536;
               x  = ref_kv[kvaddr(v.is_v, v.layer, v.head, t, d)];
               ref_sram[sa] = x;
               exp_q.push_back('{1'b1, sa, int'(x), 2 + t * v.len + d});
            end
         dc = v.tim * v.len + 2;
      end
   endtask

   task automatic drive(input vec_t v);
      bus.cmd_is_read   = v.is_read;
      bus.cmd_is_v      = v.is_v;
      bus.cmd_layer     = 16'(v.layer);
      bus.cmd_head      = 16'(v.head);
      bus.cmd_time      = 16'(v.tim);
      bus.cmd_len       = 16'(v.len);
      bus.cmd_sram_addr = 16'(v.addr);
   endtask

   task automatic check_log(input string name, input int c0, input bit chk_cyc);
      int bad;
      bad = -1;
      total++;
      if (obs_q.size() != exp_q.size()) begin
         $display("FAIL %s: got %0d writes, expected %0d", name, obs_q.size(), exp_q.size());
         return;
      end
      foreach (exp_q[i])
         if (bad < 0 && (obs_q[i].is_sram != exp_q[i].is_sram || obs_q[i].addr != exp_q[i].addr ||
             obs_q[i].data != exp_q[i].data || (chk_cyc && obs_q[i].cyc - c0 != exp_q[i].cyc)))
            bad = i;
      if (bad >= 0)
         $display("FAIL %s: write %0d got sram=%0d addr=%0h data=%0h cyc=%0d, expected sram=%0d addr=%0h data=%0h cyc=%0d",
                  name, bad, obs_q[bad].is_sram, obs_q[bad].addr, obs_q[bad].data, obs_q[bad].cyc - c0,
                  exp_q[bad].is_sram, exp_q[bad].addr, exp_q[bad].data, exp_q[bad].cyc);
      else passed++;
   endtask

   // Issues one command from an idle DUT and checks timing, error flag and every write.
   task automatic run_cmd(input vec_t v, input bit use_tbl, input string name);
      bit me, seen, derr;
      int mdc, c0, dcyc;
      exp_q.delete();
      model_cmd(v, me, mdc);
      @(negedge clk);
      obs_q.delete();
      bad_strobes = 0;
      cur_is_read = v.is_read;
      drive(v);
      bus.cmd_valid = 1'b1;
      c0 = cyc;
      check({name, ".ready"}, int'(bus.cmd_ready), 1);
      seen = 0; dcyc = 0; derr = 0;
      for (int k = 1; k <= 5000 && !seen; k++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         if (bus.done) begin seen = 1; dcyc = k; derr = bus.err; end
      end
      check({name, ".done_cycle"}, dcyc, use_tbl ? v.exp_done : mdc);
      check({name, ".err"}, int'(derr), use_tbl ? int'(v.exp_err) : int'(me));
      check_log({name, ".writes"}, c0, 1'b1);
      check({name, ".bad_strobes"}, bad_strobes, 0);
      @(negedge clk);
      check({name, ".done_pulse"}, int'(bus.done), 0);
   endtask

   vec_t tbl[12];
   vec_t v, va, vb;
   logic [7:0] x;
   int r, da, db, busy_acc, wr_cnt;
   bit em;
   int dm;

   initial begin
      bus.cmd_valid = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 65536; i++) begin x = 8'($urandom); sram_mem[i] = x; ref_sram[i] = x; end
      for (int i = 0; i < (1 << KV_AW); i++) begin x = 8'($urandom); kv_mem[i] = x; ref_kv[i] = x; end
      for (int i = 0; i < 4; i++) begin
         sram_mem['h100 + i] = 8'(11 * (i + 1));
         ref_sram['h100 + i] = 8'(11 * (i + 1));
      end

      tbl[0]  = mk(0, 0, 1, 2, 5,  4,  'h0100, 0, 6);
      tbl[1]  = mk(1, 1, 0, 3, 3,  2,  'h0200, 0, 8);
      tbl[2]  = mk(0, 0, 4, 0, 5,  4,  'h0100, 1, 1);
      tbl[3]  = mk(0, 0, 0, 0, 5,  65, 'h0100, 1, 1);
      tbl[4]  = mk(0, 0, 0, 0, 64, 4,  'h0100, 1, 1);
      tbl[5]  = mk(1, 0, 2, 1, 64, 1,  'h0300, 0, 66);
      tbl[6]  = mk(1, 0, 0, 0, 0,  4,  'h0400, 0, 1);
      tbl[7]  = mk(0, 1, 1, 1, 3,  0,  'h0100, 0, 1);
      tbl[8]  = mk(1, 0, 0, 0, 65, 2,  'h0400, 1, 1);
      tbl[9]  = mk(0, 1, 0, 4, 1,  2,  'h0010, 1, 1);
      tbl[10] = mk(0, 1, 3, 3, 63, 64, 'h1000, 0, 66);
      tbl[11] = mk(1, 0, 1, 2, 4,  8,  'hFFF0, 0, 34);

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.cmd_ready", int'(bus.cmd_ready), 1);
      check("rst.busy", int'(bus.busy), 0);
      check("rst.done_err", int'({bus.done, bus.err}), 0);
      check("rst.strobes", int'({bus.sram_rd_en, bus.sram_wr_en, bus.kv_rd_en, bus.kv_wr_en}), 0);
      rst = 1'b0;

      foreach (tbl[i]) run_cmd(tbl[i], 1'b1, $sformatf("tbl%0d", i));

      // Reset in the middle of a READ: everything stops at once.
      @(negedge clk);
      cur_is_read = 1'b1;
      drive(mk(1, 0, 1, 1, 4, 8, 'h8000, 0, 0));
      bus.cmd_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst.cmd_ready", int'(bus.cmd_ready), 1);
      r = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.sram_rd_en || bus.sram_wr_en || bus.kv_rd_en || bus.kv_wr_en || bus.done || bus.busy) r++;
         @(negedge clk);
      end
      check("midrst.quiet_cycles", r, 0);
      run_cmd(mk(0, 1, 2, 3, 9, 6, 'h0100, 0, 8), 1'b1, "midrst.append");

      // Back-to-back APPENDs with cmd_valid held high.
`ifdef KV_PERF_CNT_EN
      @(negedge clk);
      perf_clr = 1'b1;
      @(negedge clk);
      perf_clr = 1'b0;
`endif
      va = mk(0, 0, 2, 1, 7, 3, 'h0040, 0, 0);
      vb = mk(0, 1, 3, 0, 8, 5, 'h0080, 0, 0);
      exp_q.delete();
      model_cmd(va, em, dm);
      model_cmd(vb, em, dm);
      @(negedge clk);
      obs_q.delete();
      cur_is_read = 1'b0;
      drive(va);
      bus.cmd_valid = 1'b1;
      da = 0; db = 0; busy_acc = 0;
      for (int k = 1; k <= 200 && db == 0; k++) begin
         @(negedge clk);
         if (da == 0 && bus.cmd_ready) busy_acc++;
         if (da != 0 && k == da + 1) check("b2b.ready_after_done", int'(bus.cmd_ready), 1);
         if (da != 0 && k == da + 2) bus.cmd_valid = 1'b0;
         if (bus.done && da == 0) begin da = k; drive(vb); end
         else if (bus.done) db = k;
      end
      check("b2b.first_done", da, 5);
      check("b2b.second_done", db, 13);
      check("b2b.ignored_while_busy", busy_acc, 0);
      check_log("b2b.writes", 0, 1'b0);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
`ifdef KV_PERF_CNT_EN
      check("perf.elems", int'(perf_elems), 8);
      check("perf.cycles", int'(perf_cycles), 12);
      check("perf.errs0", int'(perf_errs), 0);
      run_cmd(mk(0, 0, 4, 0, 0, 1, 0, 1, 1), 1'b1, "perf.errcmd");
      check("perf.errs1", int'(perf_errs), 1);
`endif

      // Randomized commands against the reference model.
      for (int n = 0; n < 40; n++) begin
         v.is_read = 1'($urandom_range(0, 1));
         v.is_v    = 1'($urandom_range(0, 1));
         v.layer   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
         v.head    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
         r = int'($urandom_range(0, 19));
         v.len = (r == 0) ? 0 : (r == 1) ? 65 : (r == 2) ? 64 : int'($urandom_range(1, 16));
         r = int'($urandom_range(0, 15));
         if (v.is_read) begin
            v.tim  = (r == 0) ? 65 : (r == 1) ? 0 : int'($urandom_range(1, 6));
            v.addr = int'($urandom_range(0, 65535));
         end else begin
            v.tim  = (r == 0) ? 64 : int'($urandom_range(0, 63));
            v.addr = int'($urandom_range(0, 'h3FFF));
         end
         v.exp_err = 0; v.exp_done = 0;
         run_cmd(v, 1'b0, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
